// File: rtl/arc_regs_pkg.sv
// rtl/arc_regs_pkg.sv - ARC register file sizing and named register indices
package arc_regs_pkg;

  localparam int ARC_NUM_REGS = 38;
  localparam int ARC_SEL_W    = 6;

  typedef logic [ARC_SEL_W-1:0] reg_idx_t;

  localparam reg_idx_t R0    = 6'd0;
  localparam reg_idx_t PC    = 6'd32;
  localparam reg_idx_t NPC   = 6'd33;
  localparam reg_idx_t IR    = 6'd34;
  localparam reg_idx_t TEMP0 = 6'd35;
  localparam reg_idx_t TEMP1 = 6'd36;
  localparam reg_idx_t TEMP2 = 6'd37;

endpackage

// File: rtl/decoder_onehot.sv
// rtl/decoder_onehot.sv - combinational index to one-hot decoder with range/r0 check
module decoder_onehot #(
  parameter int NUM_REGS    = 38,
  parameter int SEL_W       = 6,
  parameter int PROTEGER_R0 = 1
) (
  input  logic [SEL_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot,
  output logic                valid
);

  always_comb begin
    valid  = (int'(idx) < NUM_REGS) && !((PROTEGER_R0 != 0) && (idx == '0));
    onehot = valid ? (NUM_REGS'(1) << idx) : '0;
  end

endmodule

// File: rtl/decoder_marcador.sv
// rtl/decoder_marcador.sv - registered write-enable decoder with pending-write scoreboard
module decoder_marcador
  import arc_regs_pkg::*;
#(
  parameter int NUM_REGS    = ARC_NUM_REGS,
  parameter int SEL_W       = ARC_SEL_W,
  parameter int PROTEGER_R0 = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              escribir,
  input  logic [SEL_W-1:0]                  sel_esc,
  input  logic                              reservar,
  input  logic [SEL_W-1:0]                  sel_res,
  input  logic                              vaciar,
  input  logic [SEL_W-1:0]                  sel_cons,
  output logic [NUM_REGS-1:0]               habilitador,
  output logic [NUM_REGS-1:0]               pendiente,
  output logic                              ocupado,
  output logic [$clog2(NUM_REGS+1)-1:0]     num_pend,
  output logic                              error
);

  localparam int CNT_W = $clog2(NUM_REGS+1);

  logic [NUM_REGS-1:0] oh_esc, oh_res, wr_mask, rs_mask, pend_next;
  logic                esc_valid, res_valid, ya_pend, set_eff, clr_eff, err_next;
  logic [CNT_W-1:0]    cnt_next;

  decoder_onehot #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .PROTEGER_R0(PROTEGER_R0)) u_dec_esc (
    .idx    (sel_esc),
    .onehot (oh_esc),
    .valid  (esc_valid)
  );

  decoder_onehot #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .PROTEGER_R0(PROTEGER_R0)) u_dec_res (
    .idx    (sel_res),
    .onehot (oh_res),
    .valid  (res_valid)
  );

  always_comb begin
    wr_mask = escribir ? oh_esc : '0;
    rs_mask = reservar ? oh_res : '0;
    ya_pend = |(pendiente & rs_mask);
    set_eff = (rs_mask != '0) && !ya_pend;
    // A clear on the index being re-reserved is absorbed by the new producer.
    clr_eff = (|(pendiente & wr_mask)) && (wr_mask != rs_mask);
    pend_next = vaciar ? '0 : ((pendiente & ~wr_mask) | rs_mask);
    cnt_next  = num_pend;
    if (vaciar) begin
      cnt_next = '0;
    end else if (set_eff && !clr_eff) begin
      cnt_next = num_pend + CNT_W'(1);
    end else if (clr_eff && !set_eff) begin
      cnt_next = num_pend - CNT_W'(1);
    end
    err_next = (escribir && !esc_valid) || (reservar && (!res_valid || ya_pend));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      habilitador <= '0;
      pendiente   <= '0;
      num_pend    <= '0;
      error       <= 1'b0;
    end else begin
      habilitador <= wr_mask;
      pendiente   <= pend_next;
      num_pend    <= cnt_next;
      error       <= err_next;
    end
  end

  assign ocupado = (int'(sel_cons) < NUM_REGS) ? pendiente[sel_cons] : 1'b0;

endmodule

// File: tb/tb_decoder_marcador.sv
// tb/tb_decoder_marcador.sv - directed vector bench for decoder_marcador
module tb_decoder_marcador;
  import arc_regs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        escribir, reservar, vaciar;
  logic [5:0]  sel_esc, sel_res, sel_cons;
  logic [37:0] habilitador, pendiente;
  logic        ocupado, error;
  logic [5:0]  num_pend;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        e;
    logic [5:0]  se;
    logic        r;
    logic [5:0]  sr;
    logic        v;
    logic [5:0]  sc;
    logic [37:0] hab;
    logic [37:0] pend;
    logic [5:0]  np;
    logic        oc;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  decoder_marcador dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .escribir    (escribir),
    .sel_esc     (sel_esc),
    .reservar    (reservar),
    .sel_res     (sel_res),
    .vaciar      (vaciar),
    .sel_cons    (sel_cons),
    .habilitador (habilitador),
    .pendiente   (pendiente),
    .ocupado     (ocupado),
    .num_pend    (num_pend),
    .error       (error)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] b(input int i);
    return 38'd1 << i;
  endfunction

  function automatic vec_t mk(input string n, input logic e, input int se, input logic r,
                              input int sr, input logic v, input int sc, input logic [37:0] hab,
                              input logic [37:0] pend, input int np, input logic oc, input logic err);
    vec_t t;
    t.name = n; t.e = e; t.se = 6'(se); t.r = r; t.sr = 6'(sr); t.v = v; t.sc = 6'(sc);
    t.hab = hab; t.pend = pend; t.np = 6'(np); t.oc = oc; t.err = err;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic e, input int se, input logic r, input int sr,
                       input logic v, input int sc);
    escribir = e; sel_esc = 6'(se); reservar = r; sel_res = 6'(sr); vaciar = v; sel_cons = 6'(sc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [37:0] hab, input logic [37:0] pend,
                         input int np, input logic oc, input logic err);
    chk({nm, ".hab"},  64'(habilitador), 64'(hab));
    chk({nm, ".pend"}, 64'(pendiente),   64'(pend));
    chk({nm, ".np"},   64'(num_pend),    64'(np));
    chk({nm, ".ocup"}, 64'(ocupado),     64'(oc));
    chk({nm, ".err"},  64'(error),       64'(err));
  endtask

  initial begin
    logic [37:0] p;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    vecs.push_back(mk("idle",        0, 0,  0, 0,  0, 0,  '0,     '0,                   0, 0, 0));
    vecs.push_back(mk("wr5",         1, 5,  0, 0,  0, 0,  b(5),   '0,                   0, 0, 0));
    vecs.push_back(mk("wr5_drop",    0, 0,  0, 0,  0, 0,  '0,     '0,                   0, 0, 0));
    vecs.push_back(mk("wr37",        1, 37, 0, 0,  0, 0,  b(37),  '0,                   0, 0, 0));
    vecs.push_back(mk("wr_r0",       1, 0,  0, 0,  0, 0,  '0,     '0,                   0, 0, 1));
    vecs.push_back(mk("wr40",        1, 40, 0, 0,  0, 0,  '0,     '0,                   0, 0, 1));
    vecs.push_back(mk("err_drop",    0, 0,  0, 0,  0, 0,  '0,     '0,                   0, 0, 0));
    vecs.push_back(mk("rs3",         0, 0,  1, 3,  0, 3,  '0,     b(3),                 1, 1, 0));
    vecs.push_back(mk("rs7",         0, 0,  1, 7,  0, 7,  '0,     b(3)|b(7),            2, 1, 0));
    vecs.push_back(mk("rs12",        0, 0,  1, 12, 0, 7,  '0,     b(3)|b(7)|b(12),      3, 1, 0));
    vecs.push_back(mk("wr7",         1, 7,  0, 0,  0, 7,  b(7),   b(3)|b(12),           2, 0, 0));
    vecs.push_back(mk("rs3_again",   0, 0,  1, 3,  0, 3,  '0,     b(3)|b(12),           2, 1, 1));
    vecs.push_back(mk("rs9",         0, 0,  1, 9,  0, 9,  '0,     b(3)|b(9)|b(12),      3, 1, 0));
    vecs.push_back(mk("rs9_wr9",     1, 9,  1, 9,  0, 9,  b(9),   b(3)|b(9)|b(12),      3, 1, 1));
    vecs.push_back(mk("rs4_wr12",    1, 12, 1, 4,  0, 12, b(12),  b(3)|b(4)|b(9),       3, 0, 0));
    vecs.push_back(mk("rs40",        0, 0,  1, 40, 0, 4,  '0,     b(3)|b(4)|b(9),       3, 1, 1));
    vecs.push_back(mk("rs_r0",       0, 0,  1, 0,  0, 0,  '0,     b(3)|b(4)|b(9),       3, 0, 1));
    vecs.push_back(mk("cons45",      0, 0,  0, 0,  0, 45, '0,     b(3)|b(4)|b(9),       3, 0, 0));
    vecs.push_back(mk("wr_free_pc",  1, int'(PC), 0, 0, 0, 9, b(32), b(3)|b(4)|b(9),    3, 1, 0));

    #12;
    chk_all("reset", '0, '0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].e, vecs[i].se, vecs[i].r, vecs[i].sr, vecs[i].v, vecs[i].sc);
      tick();
      chk_all(vecs[i].name, vecs[i].hab, vecs[i].pend, vecs[i].np, vecs[i].oc, vecs[i].err);
    end

    // Fill up to ten pending entries, then flush while reserving.
    p = b(3) | b(4) | b(9);
    for (int k = 10; k <= 16; k++) begin
      drive(0, 0, 1, k, 0, k);
      tick();
      p |= b(k);
      chk_all($sformatf("fill%0d", k), '0, p, k - 6, 1, 0);
    end
    drive(1, 5, 1, 2, 1, 2);
    tick();
    chk_all("flush", b(5), '0, 0, 0, 0);

    // Asynchronous reset with reservations and a write in flight.
    p = '0;
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 1, k, 0, 3);
      tick();
      p |= b(k);
    end
    chk_all("pre_rst", '0, p, 5, 1, 0);
    drive(1, 20, 0, 0, 0, 3);
    tick();
    chk_all("inflight", b(20), p, 5, 1, 0);
    drive(1, 21, 1, 6, 0, 3);
    #3 rst_n = 1'b0;
    #1;
    chk_all("async_rst", '0, '0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 3);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("post_rst%0d", k), '0, '0, 0, 0, 0);
    end
    drive(1, 6, 0, 0, 0, 6);
    tick();
    chk_all("post_rst_wr6", b(6), '0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
